// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding and
// the launch-time helpers that build byte enables and lane-replicated store data.
package lsu_pkg;

   localparam logic [2:0] DS_WORD  = 3'b000;
   localparam logic [2:0] DS_BYTE  = 3'b001;
   localparam logic [2:0] DS_HALF  = 3'b010;
   localparam logic [2:0] DS_BYTEU = 3'b011;
   localparam logic [2:0] DS_HALFU = 3'b100;

   localparam int TIMEOUT_DEF = 16;
   localparam int CNT_W_DEF   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic is_byte(input logic [2:0] ds);
      return (ds == DS_BYTE) || (ds == DS_BYTEU);
   endfunction

   function automatic logic is_half(input logic [2:0] ds);
      return (ds == DS_HALF) || (ds == DS_HALFU);
   endfunction

   // Codes 101-111 fall through to word handling in both helpers.
   function automatic logic [3:0] byte_en(input logic [2:0] ds, input logic [1:0] off);
      if (is_byte(ds)) return 4'b0001 << off;
      if (is_half(ds)) return 4'b0011 << {off[1], 1'b0};
      return 4'b1111;
   endfunction

   function automatic logic [31:0] lane_data(input logic [2:0] ds, input logic [31:0] wd);
      if (is_byte(ds)) return {4{wd[7:0]}};
      if (is_half(ds)) return {2{wd[15:0]}};
      return wd;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// req/gnt/rvalid data bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata, bus_err
   );

endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  DataSrc,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = rdata[{off, 3'b000} +: 8];
   assign half_lane = off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      // NOTE: default assignment first so every path drives data and no latch is inferred.
      data = rdata;
      case (DataSrc)
         DS_WORD:  data = rdata;
         DS_BYTE:  data = {{24{byte_lane[7]}}, byte_lane};
         DS_HALF:  data = {{16{half_lane[15]}}, half_lane};
         DS_BYTEU: data = {24'h0, byte_lane};
         DS_HALFU: data = {16'h0, half_lane};
         default:  data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage data-bus master: launches aligned loads/stores on the req/gnt/rvalid
// bus, extends load data, stalls the pipeline and flags misalignment, errors and timeouts.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        DataSrc,
   input  logic [31:0]       Addr,
   input  logic [31:0]       WriteData,
   load_store_unit_if.master bus,
   output logic [31:0]       ReadData,
   output logic              Stall,
   output logic              Done,
   output logic              MisalignExc,
   output logic              BusFault
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic [3:0]       be_q;
   logic             we_q;
   logic             fault_q;
   logic [2:0]       ds_q;
   logic [1:0]       off_q;
   logic [31:0]      load_d;

   logic access;
   logic misaligned;
   logic idle_req;
   logic launch;
   logic resp_now;
   logic timed_out;

   assign access     = MemRead | MemWrite;
   assign misaligned = is_half(DataSrc) ? Addr[0]
                                        : (!is_byte(DataSrc) && (Addr[1:0] != 2'b00));
   // Gated by rst_n so the pipeline-facing flags read 0 while reset is held.
   assign idle_req   = rst_n && (state_q == IDLE) && access;
   assign launch     = idle_req && !misaligned;
   assign resp_now   = bus.bus_rvalid &&
                       ((state_q == RESP) || ((state_q == ADDR) && bus.bus_gnt));
   assign timed_out  = (cnt_q == CNT_W'(TIMEOUT - 1));

   load_extend u_load_extend (
      .rdata   (bus.bus_rdata),
      .off     (off_q),
      .DataSrc (ds_q),
      .data    (load_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
         ds_q    <= DS_WORD;
         off_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q <= ADDR;
                  cnt_q   <= '0;
                  addr_q  <= {Addr[31:2], 2'b00};
                  be_q    <= byte_en(DataSrc, Addr[1:0]);
                  wdata_q <= lane_data(DataSrc, WriteData);
                  we_q    <= MemWrite;
                  ds_q    <= DataSrc;
                  off_q   <= Addr[1:0];
               end
            end
            ADDR, RESP: begin
               // A completing response wins over a timeout landing in the same cycle.
               if (resp_now) begin
                  state_q <= DONE;
                  if (bus.bus_err) fault_q <= 1'b1;
                  else if (!we_q)  rdata_q <= load_d;
               end else if (timed_out) begin
                  state_q <= IDLE;
                  fault_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if ((state_q == ADDR) && bus.bus_gnt) state_q <= RESP;
               end
            end
            DONE: state_q <= IDLE;
         endcase
      end
   end

   assign bus.bus_req   = (state_q == ADDR);
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;

   assign ReadData    = rdata_q;
   assign Stall       = launch || (state_q == ADDR) || (state_q == RESP);
   assign Done        = (state_q == DONE);
   assign MisalignExc = idle_req && misaligned;
   assign BusFault    = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scoreboard queue holds the expected bus
// fields and completion of each launched access and is drained as accesses finish.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] rdata;
      logic        done;
      logic        fault;
   } exp_t;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        MemRead   = 1'b0;
   logic        MemWrite  = 1'b0;
   logic [2:0]  DataSrc   = 3'b000;
   logic [31:0] Addr      = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Done;
   logic        MisalignExc;
   logic        BusFault;

   load_store_unit_if bus_if ();

   exp_t        exp_q[$];
   logic [31:0] model_rd = '0;
   int          n_vec    = 0;
   int          n_err    = 0;

   load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .DataSrc     (DataSrc),
      .Addr        (Addr),
      .WriteData   (WriteData),
      .bus         (bus_if),
      .ReadData    (ReadData),
      .Stall       (Stall),
      .Done        (Done),
      .MisalignExc (MisalignExc),
      .BusFault    (BusFault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Independent reference for one access: bus fields, extended load value and outcome.
   function automatic exp_t model(input logic mw, input logic [2:0] ds, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd, input logic err,
                                  input int gnt_dly, input int rsp_dly);
      exp_t        e;
      int          sz;
      logic [31:0] sh;
      case (ds)
         3'd1, 3'd3: sz = 1;
         3'd2, 3'd4: sz = 2;
         default:    sz = 4;
      endcase
      e.addr = {addr[31:2], 2'b00};
      if (sz == 4)      e.be = 4'b1111;
      else if (sz == 2) e.be = addr[1] ? 4'b1100 : 4'b0011;
      else              e.be = 4'(1 << addr[1:0]);
      e.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
      e.we    = mw;
      sh      = rd >> (8 * addr[1:0]);
      case (ds)
         3'd1:    e.rdata = {{24{sh[7]}}, sh[7:0]};
         3'd2:    e.rdata = {{16{sh[15]}}, sh[15:0]};
         3'd3:    e.rdata = {24'h0, sh[7:0]};
         3'd4:    e.rdata = {16'h0, sh[15:0]};
         default: e.rdata = rd;
      endcase
      e.done  = !((gnt_dly + 1 + rsp_dly) > TIMEOUT);
      e.fault = !e.done || err;
      return e;
   endfunction

   task automatic clear_bus_inputs();
      bus_if.bus_gnt    = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_err    = 1'b0;
      bus_if.bus_rdata  = 32'hA5A5_A5A5;
   endtask

   // Called just after a falling edge; acts as the memory with the given grant and response delays.
   task automatic do_access(input string tag, input logic mr, input logic mw, input logic [2:0] ds,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input logic err, input int gnt_dly, input int rsp_dly,
                            output int stall_cyc, output int req_cyc);
      exp_t e;
      int   resp_cyc = 0;
      bit   granted  = 1'b0;
      bit   finished = 1'b0;
      e         = model(mw, ds, addr, wd, rd, err, gnt_dly, rsp_dly);
      stall_cyc = 0;
      req_cyc   = 0;
      MemRead   = mr;
      MemWrite  = mw;
      DataSrc   = ds;
      Addr      = addr;
      WriteData = wd;
      exp_q.push_back(e);
      #1;
      for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
         if (Stall) stall_cyc++;
         if (Done || BusFault) begin
            e = exp_q.pop_front();
            if (e.done && !e.fault && !e.we) model_rd = e.rdata;
            check({tag, " Done"}, 32'(Done), 32'(e.done));
            check({tag, " BusFault"}, 32'(BusFault), 32'(e.fault));
            check({tag, " ReadData"}, ReadData, model_rd);
            check({tag, " Stall at end"}, 32'(Stall), 32'(!e.done));
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            clear_bus_inputs();
            finished = 1'b1;
         end else begin
            clear_bus_inputs();
            if (bus_if.bus_req) begin
               check({tag, " bus_addr"}, bus_if.bus_addr, exp_q[0].addr);
               check({tag, " bus_be"}, 32'(bus_if.bus_be), 32'(exp_q[0].be));
               check({tag, " bus_wdata"}, bus_if.bus_wdata, exp_q[0].wdata);
               check({tag, " bus_we"}, 32'(bus_if.bus_we), 32'(exp_q[0].we));
               if (req_cyc == gnt_dly) begin
                  bus_if.bus_gnt = 1'b1;
                  granted        = 1'b1;
                  if (rsp_dly == 0) begin
                     bus_if.bus_rvalid = 1'b1;
                     bus_if.bus_err    = err;
                     bus_if.bus_rdata  = rd;
                  end
               end
               req_cyc++;
            end else if (granted) begin
               resp_cyc++;
               if (resp_cyc == rsp_dly) begin
                  bus_if.bus_rvalid = 1'b1;
                  bus_if.bus_err    = err;
                  bus_if.bus_rdata  = rd;
               end
            end
            @(negedge clk);
            #1;
         end
      end
      check({tag, " completed in budget"}, 32'(finished), 32'd1);
      if (!finished) begin
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         clear_bus_inputs();
         exp_q.delete();
      end
      @(negedge clk);
      #1;
      check({tag, " pulses cleared"}, {30'b0, Done, BusFault}, 32'd0);
   endtask

   initial begin
      int   sc;
      int   rc;
      logic req_seen;
      clear_bus_inputs();
      #1;
      check("reset ReadData", ReadData, 32'h0);
      check("reset flags", {27'b0, bus_if.bus_req, Stall, Done, MisalignExc, BusFault}, 32'h0);
      check("reset bus fields", bus_if.bus_addr | bus_if.bus_wdata |
            {28'b0, bus_if.bus_be} | {31'b0, bus_if.bus_we}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      do_access("LB zero-wait", 1'b1, 1'b0, DS_BYTE, 32'h103, 32'h0, 32'h8012_3456, 1'b0, 0, 0, sc, rc);
      check("LB stall cycles", sc, 32'd2);
      check("LB ReadData", ReadData, 32'hFFFF_FF80);

      do_access("LHU gnt delay", 1'b1, 1'b0, DS_HALFU, 32'h202, 32'h0, 32'h8001_1234, 1'b0, 3, 1, sc, rc);
      check("LHU ReadData", ReadData, 32'h0000_8001);
      check("LHU req cycles", rc, 32'd4);

      do_access("SB", 1'b0, 1'b1, DS_BYTE, 32'h301, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 0, 1, sc, rc);
      check("SB ReadData held", ReadData, 32'h0000_8001);

      MemRead = 1'b1; DataSrc = DS_WORD; Addr = 32'h102;
      #1;
      check("LW misalign exc", 32'(MisalignExc), 32'd1);
      check("LW misalign stall", 32'(Stall), 32'd0);
      req_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         req_seen = req_seen | bus_if.bus_req | !MisalignExc;
      end
      check("LW misalign no req", 32'(req_seen), 32'd0);
      MemRead = 1'b0; MemWrite = 1'b1; DataSrc = DS_HALF; Addr = 32'h101;
      #1;
      check("SH misalign exc", 32'(MisalignExc), 32'd1);
      check("SH misalign stall", 32'(Stall), 32'd0);
      req_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         req_seen = req_seen | bus_if.bus_req | !MisalignExc;
      end
      check("SH misalign no req", 32'(req_seen), 32'd0);
      MemWrite = 1'b0;
      @(negedge clk);
      #1;

      do_access("LH upper", 1'b1, 1'b0, DS_HALF, 32'h002, 32'h0, 32'hF00D_0000, 1'b0, 0, 2, sc, rc);
      check("LH ReadData", ReadData, 32'hFFFF_F00D);
      check("LH stall cycles", sc, 32'd4);
      do_access("LBU lane1", 1'b1, 1'b0, DS_BYTEU, 32'h001, 32'h0, 32'h0000_9C00, 1'b0, 1, 0, sc, rc);
      check("LBU ReadData", ReadData, 32'h0000_009C);
      do_access("SW rd+wr", 1'b1, 1'b1, DS_WORD, 32'h010, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 0, sc, rc);
      check("SW ReadData held", ReadData, 32'h0000_009C);
      do_access("SH upper", 1'b0, 1'b1, DS_HALF, 32'h012, 32'h1234_BEEF, 32'h0, 1'b0, 2, 0, sc, rc);
      do_access("LW code110", 1'b1, 1'b0, 3'b110, 32'h020, 32'h0, 32'h1357_9BDF, 1'b0, 0, 0, sc, rc);
      check("LW code110 ReadData", ReadData, 32'h1357_9BDF);

      do_access("LW timeout", 1'b1, 1'b0, DS_WORD, 32'h030, 32'h0, 32'h1111_2222, 1'b0, 100, 0, sc, rc);
      check("timeout req cycles", rc, TIMEOUT);
      do_access("LW bus err", 1'b1, 1'b0, DS_WORD, 32'h034, 32'h0, 32'h5555_AAAA, 1'b1, 0, 1, sc, rc);
      check("bus err ReadData held", ReadData, 32'h1357_9BDF);

      MemRead = 1'b1; DataSrc = DS_WORD; Addr = 32'h400;
      @(negedge clk);
      #1;
      check("rstmid req", 32'(bus_if.bus_req), 32'd1);
      bus_if.bus_gnt = 1'b1;
      @(negedge clk);
      #1;
      bus_if.bus_gnt = 1'b0;
      check("rstmid in RESP", 32'({Stall, bus_if.bus_req}), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      model_rd = '0;
      check("rstmid ReadData", ReadData, model_rd);
      check("rstmid flags", {27'b0, bus_if.bus_req, Stall, Done, MisalignExc, BusFault}, 32'h0);
      check("rstmid bus fields", bus_if.bus_addr | bus_if.bus_wdata |
            {28'b0, bus_if.bus_be} | {31'b0, bus_if.bus_we}, 32'h0);
      @(negedge clk);
      MemRead = 1'b0;
      rst_n   = 1'b1;
      #1;
      check("after release idle", {29'b0, Stall, bus_if.bus_req, Done}, 32'h0);
      do_access("LW post-reset", 1'b1, 1'b0, DS_WORD, 32'h404, 32'h0, 32'h1234_5678, 1'b0, 1, 2, sc, rc);
      check("post-reset ReadData", ReadData, 32'h1234_5678);
      check("post-reset stall cycles", sc, 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
